// File: rtl/sal_rd_resp_path_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sal_rd_resp_path_pkg
// Description : Shared DDR2 controller read-path definitions. Holds the DFI
//               and AXI widths, the read tag carried from the scheduler to the
//               R channel, and the AXI response encodings.
// Revision    : 1.0  initial release
// ============================================================================
package sal_rd_resp_path_pkg;

    localparam int DFI_DW = 64;
    localparam int AXI_DW = 2 * DFI_DW;
    localparam int ID_W   = 4;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // One tag per issued RD command, consumed in issue order.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } rd_tag_t;

endpackage : sal_rd_resp_path_pkg
`default_nettype wire

// File: rtl/sal_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sal_sync_fifo
// Description : Single-clock FIFO with registered pointers and an
//               asynchronous-read storage array. The head entry is presented
//               on pop_data whenever the FIFO is not empty.
// Ports       : clk, rst_n        clock, async active-low reset
//               push, push_data   write request and data (dropped when full)
//               pop, pop_data     read request and head entry
//               full, empty       occupancy flags
//               count             number of stored entries (0..DEPTH)
// Revision    : 1.0  initial release
// ============================================================================
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // The extra pointer MSB separates "full" (MSBs differ) from "empty"
    // (MSBs equal) when the index bits match; pointers wrap naturally.
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count    = r_wr_ptr - r_rd_ptr;

    assign w_wr_en  = push & ~full;
    assign w_rd_en  = pop & ~empty;

    assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule : sal_sync_fifo
`default_nettype wire

// File: rtl/sal_rd_resp_path.sv
`default_nettype none
// ============================================================================
// Module      : sal_rd_resp_path
// Description : DDR2 read-return datapath. Pairs DFI read-data cycles into
//               AXI beats (one BL4 burst = two DFI cycles = one beat), tags
//               each beat in issue order with the ID/last pushed by the
//               scheduler, and buffers beats so R backpressure never reaches
//               DFI. Admission (tag_ready_o) bounds outstanding reads to DEPTH
//               so the beat buffer cannot overflow.
// Ports       : clk, rst_n                     clock, async active-low reset
//               tag_valid_i/id_i/last_i        RD issued by scheduler
//               tag_ready_o                    an RD may be issued
//               dfi_rddata_valid_i/rddata_i    DFI read data half-beats
//               rvalid_o/rready_i/rid_o/rdata_o/rresp_o/rlast_o  AXI R
//               err_orphan_o                   sticky: data with no tag
// Revision    : 1.0  initial release
// ============================================================================
module sal_rd_resp_path #(
    parameter int DFI_DW = sal_rd_resp_path_pkg::DFI_DW,
    parameter int AXI_DW = sal_rd_resp_path_pkg::AXI_DW,
    parameter int ID_W   = sal_rd_resp_path_pkg::ID_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tag_valid_i,
    input  logic [ID_W-1:0]   tag_id_i,
    input  logic              tag_last_i,
    output logic              tag_ready_o,
    input  logic              dfi_rddata_valid_i,
    input  logic [DFI_DW-1:0] dfi_rddata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [ID_W-1:0]   rid_o,
    output logic [AXI_DW-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              err_orphan_o
);

    import sal_rd_resp_path_pkg::*;

    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_out_cnt;
    logic               r_phase;
    logic [DFI_DW-1:0]  r_low_half;
    logic               r_err_orphan;

    logic               w_tag_push;
    logic               w_rd_hs;
    logic               w_beat_done;
    logic               w_orphan;
    logic               w_data_push;
    logic [AXI_DW-1:0]  w_beat;

    rd_tag_t            w_tag_in;
    rd_tag_t            w_tag_head;
    logic               w_tag_full;
    logic               w_tag_empty;
    logic [c_CNT_W-1:0] w_tag_count;
    logic               w_data_full;
    logic               w_data_empty;
    logic [c_CNT_W-1:0] w_data_count;

    // ------------------------------------------------------------------
    // Admission and handshakes
    // ------------------------------------------------------------------
    assign tag_ready_o = (r_out_cnt < c_DEPTH);
    // A push offered while not ready is ignored rather than corrupting state.
    assign w_tag_push  = tag_valid_i & tag_ready_o;
    assign w_rd_hs     = rvalid_o & rready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_tag_push, w_rd_hs})
                2'b10:   r_out_cnt <= r_out_cnt + c_ONE;
                2'b01:   r_out_cnt <= r_out_cnt - c_ONE;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat assembler: first DFI cycle is the low half of the AXI beat.
    // ------------------------------------------------------------------
    assign w_beat_done = dfi_rddata_valid_i & r_phase;
    assign w_beat      = {dfi_rddata_i, r_low_half};

    // Tags and beats pop together, so the count difference is the number of
    // issued reads still waiting for their data. Zero means nobody asked.
    assign w_orphan    = w_beat_done & (w_tag_count == w_data_count);
    assign w_data_push = w_beat_done & ~w_orphan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= 1'b0;
            r_low_half   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (dfi_rddata_valid_i) begin
                if (!r_phase) begin
                    r_low_half <= dfi_rddata_i;
                end
                r_phase <= ~r_phase;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign err_orphan_o = r_err_orphan;

    // ------------------------------------------------------------------
    // Tag and beat buffers
    // ------------------------------------------------------------------
    assign w_tag_in.id   = tag_id_i;
    assign w_tag_in.last = tag_last_i;

    sal_sync_fifo #(
        .WIDTH ($bits(rd_tag_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_tag_push),
        .push_data (w_tag_in),
        .pop       (w_rd_hs),
        .pop_data  (w_tag_head),
        .full      (w_tag_full),
        .empty     (w_tag_empty),
        .count     (w_tag_count)
    );

    sal_sync_fifo #(
        .WIDTH (AXI_DW),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_data_push),
        .push_data (w_beat),
        .pop       (w_rd_hs),
        .pop_data  (rdata_o),
        .full      (w_data_full),
        .empty     (w_data_empty),
        .count     (w_data_count)
    );

    // ------------------------------------------------------------------
    // AXI R channel
    // ------------------------------------------------------------------
    assign rvalid_o = ~w_data_empty;
    assign rid_o    = w_tag_head.id;
    assign rlast_o  = w_tag_head.last;
    assign rresp_o  = RRESP_OKAY;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_tag_push_when_not_ready : assert property (
        @(posedge clk) disable iff (!rst_n) !(tag_valid_i && !tag_ready_o));

    a_tag_fifo_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_tag_push && w_tag_full));

    a_data_fifo_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_data_push && w_data_full));

    a_beat_has_tag : assert property (
        @(posedge clk) disable iff (!rst_n) !(rvalid_o && w_tag_empty));

endmodule : sal_rd_resp_path
`default_nettype wire

// File: tb/tb_sal_rd_resp_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_sal_rd_resp_path
// Description : Directed self-checking bench for sal_rd_resp_path. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sal_rd_resp_path;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tag_valid_i;
    logic [3:0]   tag_id_i;
    logic         tag_last_i;
    logic         tag_ready_o;
    logic         dfi_rddata_valid_i;
    logic [63:0]  dfi_rddata_i;
    logic         rvalid_o;
    logic         rready_i;
    logic [3:0]   rid_o;
    logic [127:0] rdata_o;
    logic [1:0]   rresp_o;
    logic         rlast_o;
    logic         err_orphan_o;

    always #5 clk = ~clk;

    sal_rd_resp_path dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tag_valid_i        (tag_valid_i),
        .tag_id_i           (tag_id_i),
        .tag_last_i         (tag_last_i),
        .tag_ready_o        (tag_ready_o),
        .dfi_rddata_valid_i (dfi_rddata_valid_i),
        .dfi_rddata_i       (dfi_rddata_i),
        .rvalid_o           (rvalid_o),
        .rready_i           (rready_i),
        .rid_o              (rid_o),
        .rdata_o            (rdata_o),
        .rresp_o            (rresp_o),
        .rlast_o            (rlast_o),
        .err_orphan_o       (err_orphan_o)
    );

    typedef struct {
        logic [3:0]   id;
        logic         last;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tag(input logic [3:0] id, input logic last);
        tag_valid_i = 1'b1;
        tag_id_i    = id;
        tag_last_i  = last;
        @(negedge clk);
        tag_valid_i = 1'b0;
    endtask

    task automatic dfi(input logic [63:0] d);
        dfi_rddata_valid_i = 1'b1;
        dfi_rddata_i       = d;
        @(negedge clk);
        dfi_rddata_valid_i = 1'b0;
    endtask

    task automatic expect_beat(input logic [3:0] id, input logic last,
                               input logic [63:0] lo, input logic [63:0] hi);
        exp_t e;
        e.id   = id;
        e.last = last;
        e.data = {hi, lo};
        exp_q.push_back(e);
    endtask

    // Consume n beats; with rand_rdy, stall randomly and verify the payload
    // holds while stalled.
    task automatic drain(input int n, input bit rand_rdy);
        int           got = 0;
        int           cyc = 0;
        bit           stalled = 1'b0;
        logic [3:0]   p_id = '0;
        logic         p_last = 1'b0;
        logic [127:0] p_data = '0;
        exp_t         e;
        while (got < n && cyc < 200) begin
            if (stalled) begin
                chk("stall_rvalid", 128'(rvalid_o), 128'(1));
                chk("stall_rid",    128'(rid_o),    128'(p_id));
                chk("stall_rlast",  128'(rlast_o),  128'(p_last));
                chk("stall_rdata",  rdata_o,        p_data);
            end
            if (!rand_rdy) chk("beat_rvalid", 128'(rvalid_o), 128'(1));
            rready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled  = 1'b0;
            if (rvalid_o) begin
                if (rready_i) begin
                    e = exp_q.pop_front();
                    chk("beat_rid",   128'(rid_o),   128'(e.id));
                    chk("beat_rlast", 128'(rlast_o), 128'(e.last));
                    chk("beat_rdata", rdata_o,       e.data);
                    chk("beat_rresp", 128'(rresp_o), 128'(0));
                    got++;
                end else begin
                    stalled = 1'b1;
                    p_id    = rid_o;
                    p_last  = rlast_o;
                    p_data  = rdata_o;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready_i = 1'b0;
        if (got < n) chk("drain_timeout", 128'(got), 128'(n));
    endtask

    initial begin
        logic [63:0] lo;
        logic [63:0] hi;
        exp_t        e;

        rst_n              = 1'b0;
        tag_valid_i        = 1'b0;
        tag_id_i           = '0;
        tag_last_i         = 1'b0;
        dfi_rddata_valid_i = 1'b0;
        dfi_rddata_i       = '0;
        rready_i           = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_tag_ready", 128'(tag_ready_o),  128'(1));
        chk("rst_rvalid",    128'(rvalid_o),     128'(0));
        chk("rst_err",       128'(err_orphan_o), 128'(0));

        // Single beat
        push_tag(4'd3, 1'b1);
        dfi(64'h1111_1111_1111_1111);
        chk("single_no_early_rvalid", 128'(rvalid_o), 128'(0));
        dfi(64'h2222_2222_2222_2222);
        chk("single_rvalid", 128'(rvalid_o), 128'(1));
        chk("single_rid",    128'(rid_o),    128'(3));
        chk("single_rlast",  128'(rlast_o),  128'(1));
        chk("single_rresp",  128'(rresp_o),  128'(0));
        chk("single_rdata",  rdata_o,
            128'h2222_2222_2222_2222_1111_1111_1111_1111);
        rready_i = 1'b1;
        @(negedge clk);
        rready_i = 1'b0;
        chk("single_empty_after", 128'(rvalid_o), 128'(0));

        // Burst of 4, last on the 4th beat only
        for (int i = 0; i < 4; i++) push_tag(4'd5, (i == 3));
        for (int i = 0; i < 4; i++) begin
            lo = 64'hA5A5_0000_0000_0000 | 64'(i);
            hi = 64'h5A5A_0000_0000_0000 | 64'(i);
            expect_beat(4'd5, (i == 3), lo, hi);
            dfi(lo);
            dfi(hi);
        end
        drain(4, 1'b0);

        // Full admission, then backpressured drain
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("adm_ready_at_7", 128'(tag_ready_o), 128'(1));
            push_tag(4'(i), 1'b1);
        end
        chk("adm_not_ready_at_8", 128'(tag_ready_o), 128'(0));
        for (int i = 0; i < 8; i++) begin
            lo = 64'hC0DE_0000_0000_0000 | 64'(i);
            hi = 64'hBEEF_0000_0000_0000 | 64'(i << 4);
            expect_beat(4'(i), 1'b1, lo, hi);
            dfi(lo);
            dfi(hi);
        end
        chk("adm_still_not_ready", 128'(tag_ready_o), 128'(0));
        chk("adm_rvalid",          128'(rvalid_o),    128'(1));
        e = exp_q.pop_front();
        chk("adm_head_rid",   128'(rid_o), 128'(e.id));
        chk("adm_head_rdata", rdata_o,     e.data);
        rready_i = 1'b1;
        @(negedge clk);
        rready_i = 1'b0;
        chk("adm_ready_after_hs", 128'(tag_ready_o), 128'(1));
        drain(7, 1'b1);
        chk("adm_all_drained", 128'(rvalid_o), 128'(0));

        // Orphan data
        dfi(64'hDEAD_DEAD_DEAD_DEAD);
        dfi(64'hBAD0_BAD0_BAD0_BAD0);
        chk("orphan_err",    128'(err_orphan_o), 128'(1));
        chk("orphan_rvalid", 128'(rvalid_o),     128'(0));
        @(negedge clk);
        chk("orphan_sticky", 128'(err_orphan_o), 128'(1));
        push_tag(4'd9, 1'b1);
        expect_beat(4'd9, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        dfi(64'h0123_4567_89AB_CDEF);
        dfi(64'hFEDC_BA98_7654_3210);
        drain(1, 1'b0);
        chk("orphan_sticky_after", 128'(err_orphan_o), 128'(1));

        // Reset mid-beat
        dfi(64'h7777_7777_7777_7777);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_err",       128'(err_orphan_o), 128'(0));
        chk("rst2_rvalid",    128'(rvalid_o),     128'(0));
        chk("rst2_tag_ready", 128'(tag_ready_o),  128'(1));
        push_tag(4'd12, 1'b0);
        dfi(64'hAAAA_0000_0000_0001);
        chk("rst2_no_stale_beat", 128'(rvalid_o), 128'(0));
        dfi(64'hBBBB_0000_0000_0002);
        expect_beat(4'd12, 1'b0, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002);
        drain(1, 1'b0);
        chk("final_err", 128'(err_orphan_o), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sal_rd_resp_path
`default_nettype wire
